// File: rtl/cpu_dmem_responder_if.sv
// CPU data-bus bundle: single-beat request from the CPU, one-cycle ack with read data back.
// No backpressure: the responder acks every accepted request; requests while busy are dropped.
interface cpu_dmem_responder_if;
   logic        cpu_request;
   logic [31:0] cpu_address;
   logic        cpu_write;
   logic [3:0]  cpu_wstrb;
   logic [31:0] cpu_wdata;
   logic [31:0] cpu_rdata;
   logic        cpu_ack;

   modport master (
      output cpu_request, cpu_address, cpu_write, cpu_wstrb, cpu_wdata,
      input  cpu_rdata, cpu_ack
   );

   modport slave (
      input  cpu_request, cpu_address, cpu_write, cpu_wstrb, cpu_wdata,
      output cpu_rdata, cpu_ack
   );
endinterface

// File: rtl/cpu_dmem_responder.sv
// Data-bus target: byte-strobed RAM plus LEDS/CYCLES/ERRCNT MMIO; ack WAIT_STATES+1 cycles after request.
// No stall path: a request arriving during WAIT is dropped and latches the sticky protocol error.
module cpu_dmem_responder #(
   parameter int ADDR_BITS   = 12,
   parameter int WAIT_STATES = 0
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   cpu_dmem_responder_if.slave  bus,
   output logic [7:0]           o_leds,
   output logic                 o_proto_error
);
   localparam int         WORDS = 2 ** (ADDR_BITS - 2);
   localparam logic [3:0] WS    = 4'(WAIT_STATES);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t      r_state, w_next;
   logic [3:0]  r_cnt;
   logic [31:2] r_addr;
   logic        r_write;
   logic [3:0]  r_wstrb;
   logic [31:0] r_wdata;
   logic [31:0] r_rdata;
   logic [31:0] r_cycles;
   logic [15:0] r_errcnt;
   logic [7:0]  r_leds;
   logic        r_proto_err;
   logic [31:0] r_mem [WORDS];

   logic                 w_accept;
   logic                 w_enter_resp;
   logic [31:2]          w_addr;
   logic                 w_write;
   logic [3:0]           w_wstrb;
   logic [31:0]          w_wdata;
   logic                 w_is_ram;
   logic                 w_is_mmio;
   logic [ADDR_BITS-3:0] w_idx;
   logic [31:0]          w_rd_word;

   assign w_accept     = bus.cpu_request && (r_state != S_WAIT);
   assign w_enter_resp = (w_next == S_RESP);

   // With no wait states the access completes on the capture edge, so decode straight off the bus.
   assign w_addr  = (r_state == S_WAIT) ? r_addr  : bus.cpu_address[31:2];
   assign w_write = (r_state == S_WAIT) ? r_write : bus.cpu_write;
   assign w_wstrb = (r_state == S_WAIT) ? r_wstrb : bus.cpu_wstrb;
   assign w_wdata = (r_state == S_WAIT) ? r_wdata : bus.cpu_wdata;

   assign w_is_ram  = (w_addr[31:ADDR_BITS] == '0);
   assign w_is_mmio = (w_addr[31:4] == 28'hE000000);
   assign w_idx     = w_addr[ADDR_BITS-1:2];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE, S_RESP: begin
            if (w_accept) w_next = (WS == 4'd0) ? S_RESP : S_WAIT;
            else          w_next = S_IDLE;
         end
         S_WAIT: begin
            if (r_cnt == 4'd1) w_next = S_RESP;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      bus.cpu_ack   = (r_state == S_RESP);
      bus.cpu_rdata = r_rdata;
      o_leds        = r_leds;
      o_proto_error = r_proto_err;
   end

   always_comb begin
      w_rd_word = '0;
      if (w_is_ram) begin
         w_rd_word = r_mem[w_idx];
      end else if (w_is_mmio) begin
         case (w_addr[3:2])
            2'd0:    w_rd_word = {24'h0, r_leds};
            2'd1:    w_rd_word = r_cycles;
            2'd2:    w_rd_word = {16'h0, r_errcnt};
            default: w_rd_word = '0;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt       <= '0;
         r_addr      <= '0;
         r_write     <= 1'b0;
         r_wstrb     <= '0;
         r_wdata     <= '0;
         r_rdata     <= '0;
         r_cycles    <= '0;
         r_errcnt    <= '0;
         r_leds      <= '0;
         r_proto_err <= 1'b0;
      end else begin
         r_cycles <= r_cycles + 32'd1;
         if (bus.cpu_request && (r_state == S_WAIT)) r_proto_err <= 1'b1;

         if (w_accept) begin
            r_addr  <= bus.cpu_address[31:2];
            r_write <= bus.cpu_write;
            r_wstrb <= bus.cpu_wstrb;
            r_wdata <= bus.cpu_wdata;
            r_cnt   <= WS;
         end else if (r_state == S_WAIT) begin
            r_cnt <= r_cnt - 4'd1;
         end

         // All architectural side effects land on the edge that enters RESP.
         if (w_enter_resp) begin
            r_rdata <= w_write ? 32'h0 : w_rd_word;
            if (!w_is_ram && !w_is_mmio && (r_errcnt != 16'hFFFF)) r_errcnt <= r_errcnt + 16'd1;
            if (w_is_mmio && w_write && (w_addr[3:2] == 2'd0) && w_wstrb[0]) r_leds <= w_wdata[7:0];
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_enter_resp && w_write && w_is_ram) begin
         for (int b = 0; b < 4; b++) begin
            if (w_wstrb[b]) r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
         end
      end
   end
endmodule

// File: tb/tb_cpu_dmem_responder.sv
// Bench: two responders (0 and 3 wait states) driven by directed and random single-beat traffic,
// checked by a queue scoreboard against a word-level memory/register model.
module tb_cpu_dmem_responder;
   localparam int K_NOCHK = 0;
   localparam int K_RD    = 1;
   localparam int K_CYC   = 2;

   typedef struct {
      int          cyc;
      int          kind;
      logic [31:0] rdata;
      logic [7:0]  leds;
   } exp_t;

   logic clk = 1'b0;
   logic rst0_n, rst1_n;
   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail = 0;

   cpu_dmem_responder_if bus0();
   cpu_dmem_responder_if bus1();
   logic [7:0] leds0, leds1;
   logic       perr0, perr1;

   cpu_dmem_responder #(.ADDR_BITS(12), .WAIT_STATES(0)) u_dut0 (
      .i_clk(clk), .i_rst_n(rst0_n), .bus(bus0), .o_leds(leds0), .o_proto_error(perr0));
   cpu_dmem_responder #(.ADDR_BITS(12), .WAIT_STATES(3)) u_dut3 (
      .i_clk(clk), .i_rst_n(rst1_n), .bus(bus1), .o_leds(leds1), .o_proto_error(perr1));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Reference model, one copy per responder (index 0: 0 wait states, index 1: 3 wait states).
   logic [31:0] mem_m   [2][1024];
   bit          known_m [2][1024];
   logic [7:0]  leds_m  [2];
   logic [15:0] err_m   [2];
   bit          have_prev [2];
   logic [31:0] prev_val  [2];
   int          prev_ack  [2];

   exp_t q0[$];
   exp_t q1[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic int qsize(input int d);
      return (d == 0) ? q0.size() : q1.size();
   endfunction

   function automatic bit is_ram(input logic [31:0] a);
      return a < 32'h0000_1000;
   endfunction

   function automatic bit is_mmio(input logic [31:0] a);
      return (a >= 32'hE000_0000) && (a <= 32'hE000_000F);
   endfunction

   function automatic void m_write(input int d, input logic [31:0] a, input logic [3:0] s,
                                   input logic [31:0] dat);
      int w;
      w = int'(a) / 4;
      if (is_ram(a)) begin
         for (int b = 0; b < 4; b++)
            if (s[b]) mem_m[d][w][8*b +: 8] = dat[8*b +: 8];
      end else if (is_mmio(a)) begin
         if ((a - 32'hE000_0000) < 32'd4 && s[0]) leds_m[d] = dat[7:0];
      end else if (err_m[d] != 16'hFFFF) begin
         err_m[d] = err_m[d] + 16'd1;
      end
   endfunction

   function automatic logic [31:0] m_read(input int d, input logic [31:0] a, output int kind);
      logic [31:0] off;
      kind = K_RD;
      if (is_ram(a)) begin
         if (!known_m[d][int'(a) / 4]) kind = K_NOCHK;
         return mem_m[d][int'(a) / 4];
      end
      if (is_mmio(a)) begin
         off = (a - 32'hE000_0000) / 4;
         if (off == 32'd0) return {24'h0, leds_m[d]};
         if (off == 32'd1) begin kind = K_CYC; return 32'h0; end
         if (off == 32'd2) return {16'h0, err_m[d]};
         return 32'h0;
      end
      if (err_m[d] != 16'hFFFF) err_m[d] = err_m[d] + 16'd1;
      return 32'h0;
   endfunction

   task automatic drive(input int d, input logic r, input logic wr, input logic [31:0] a,
                        input logic [3:0] s, input logic [31:0] dat);
      if (d == 0) begin
         bus0.cpu_request = r; bus0.cpu_write = wr; bus0.cpu_address = a;
         bus0.cpu_wstrb = s; bus0.cpu_wdata = dat;
      end else begin
         bus1.cpu_request = r; bus1.cpu_write = wr; bus1.cpu_address = a;
         bus1.cpu_wstrb = s; bus1.cpu_wdata = dat;
      end
   endtask

   // Issue one request in the current cycle; request stays high until the caller idles the bus.
   task automatic req(input int d, input logic wr, input logic [31:0] a, input logic [3:0] s,
                      input logic [31:0] dat);
      exp_t e;
      int   k;
      e.cyc   = cyc + ((d == 0) ? 1 : 4);
      e.kind  = K_NOCHK;
      e.rdata = '0;
      if (wr) begin
         m_write(d, a, s, dat);
         if (is_ram(a) && s == 4'hF) known_m[d][int'(a) / 4] = 1'b1;
      end else begin
         e.rdata = m_read(d, a, k);
         e.kind  = k;
      end
      e.leds = leds_m[d];
      drive(d, 1'b1, wr, a, s, dat);
      if (d == 0) q0.push_back(e); else q1.push_back(e);
      @(posedge clk); #1;
   endtask

   task automatic idle(input int d, input int n);
      drive(d, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic drain(input int d);
      drive(d, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      for (int i = 0; i < 40; i++) begin
         if (qsize(d) == 0) break;
         @(posedge clk); #1;
      end
      chk("drain_queue_empty", 32'(qsize(d)), 32'd0);
   endtask

   task automatic on_ack(input int d, input logic [31:0] rd, input logic [7:0] ld);
      exp_t e;
      if (qsize(d) == 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL unexpected_ack dut%0d: got ack, expected none (cycle %0d)", d, cyc);
         return;
      end
      if (d == 0) e = q0.pop_front(); else e = q1.pop_front();
      chk("ack_cycle", 32'(cyc), 32'(e.cyc));
      chk("leds_at_ack", {24'h0, ld}, {24'h0, e.leds});
      if (e.kind == K_RD) begin
         chk("rdata", rd, e.rdata);
      end else if (e.kind == K_CYC) begin
         if (have_prev[d]) chk("cycles_delta", rd - prev_val[d], 32'(cyc - prev_ack[d]));
         have_prev[d] = 1'b1;
         prev_val[d]  = rd;
         prev_ack[d]  = cyc;
      end
   endtask

   always @(negedge clk) begin
      if (bus0.cpu_ack === 1'b1) on_ack(0, bus0.cpu_rdata, leds0);
      if (bus1.cpu_ack === 1'b1) on_ack(1, bus1.cpu_rdata, leds1);
   end

   task automatic chk_reset_state(input int d);
      if (d == 0) begin
         chk("rst_ack0", {31'h0, bus0.cpu_ack}, 32'h0);
         chk("rst_rdata0", bus0.cpu_rdata, 32'h0);
         chk("rst_leds0", {24'h0, leds0}, 32'h0);
         chk("rst_perr0", {31'h0, perr0}, 32'h0);
      end else begin
         chk("rst_ack3", {31'h0, bus1.cpu_ack}, 32'h0);
         chk("rst_rdata3", bus1.cpu_rdata, 32'h0);
         chk("rst_leds3", {24'h0, leds1}, 32'h0);
         chk("rst_perr3", {31'h0, perr1}, 32'h0);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] a, dat;
      logic [3:0]  s;
      logic        wr;
      int          r, g;

      for (int d = 0; d < 2; d++) begin
         leds_m[d] = '0; err_m[d] = '0; have_prev[d] = 1'b0;
      end
      drive(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      drive(1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      rst0_n = 1'b0;
      rst1_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_reset_state(0);
      chk_reset_state(1);
      rst0_n = 1'b1;
      rst1_n = 1'b1;
      idle(0, 2);

      // Zero-wait responder: back-to-back fill of words 0..15, then directed cases.
      for (int i = 0; i < 16; i++) req(0, 1'b1, 32'(i * 4), 4'hF, $urandom);
      drain(0);
      req(0, 1'b1, 32'h10, 4'hF, 32'hCAFEBABE);
      idle(0, 1);
      req(0, 1'b0, 32'h10, 4'h0, 32'h0);
      idle(0, 1);
      req(0, 1'b1, 32'h20, 4'hF, 32'h11223344);
      req(0, 1'b1, 32'h20, 4'h5, 32'hAABBCCDD);
      req(0, 1'b0, 32'h20, 4'h0, 32'h0);
      drain(0);
      req(0, 1'b1, 32'hE000_0000, 4'hF, 32'h0000_01A5);
      req(0, 1'b0, 32'hE000_0000, 4'h0, 32'h0);
      req(0, 1'b1, 32'hE000_0004, 4'hF, 32'h1234_5678);
      req(0, 1'b0, 32'hE000_0008, 4'h0, 32'h0);
      req(0, 1'b0, 32'hE000_0004, 4'h0, 32'h0);
      idle(0, 7);
      req(0, 1'b0, 32'hE000_0004, 4'h0, 32'h0);
      req(0, 1'b0, 32'hE000_000C, 4'h0, 32'h0);
      drain(0);

      for (int i = 0; i < 300; i++) begin
         r  = $urandom_range(0, 99);
         wr = 1'($urandom_range(0, 1));
         s  = 4'($urandom_range(0, 15));
         dat = $urandom;
         if (r < 60)      a = 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 3));
         else if (r < 85) a = 32'hE000_0000 + 32'($urandom_range(0, 15));
         else             a = 32'h8000_0000 | ($urandom & 32'h0FFF_FFFF);
         req(0, wr, a, s, dat);
         g = $urandom_range(0, 2);
         if (g > 0) idle(0, g);
      end
      drain(0);
      chk("perr0_after_traffic", {31'h0, perr0}, 32'h0);

      // Three-wait responder: latency, dropped request while busy, unmapped accesses, reset mid-WAIT.
      req(1, 1'b1, 32'h40, 4'hF, 32'h5A5A_1234);
      drain(1);
      req(1, 1'b0, 32'h40, 4'h0, 32'h0);
      idle(1, 1);
      drive(1, 1'b1, 1'b0, 32'h44, 4'h0, 32'h0);
      @(posedge clk); #1;
      drain(1);
      idle(1, 8);
      chk("perr3_after_drop", {31'h0, perr1}, 32'h1);
      req(1, 1'b1, 32'hE000_0000, 4'hF, 32'h0000_003C);
      drain(1);
      req(1, 1'b0, 32'h8000_0000, 4'h0, 32'h0);
      drain(1);
      req(1, 1'b0, 32'hE000_0008, 4'h0, 32'h0);
      drain(1);
      req(1, 1'b1, 32'h8000_0040, 4'hF, 32'hDEAD_BEEF);
      drain(1);
      req(1, 1'b0, 32'hE000_0008, 4'h0, 32'h0);
      drain(1);
      req(1, 1'b0, 32'h40, 4'h0, 32'h0);
      drain(1);

      drive(1, 1'b1, 1'b1, 32'hE000_0000, 4'hF, 32'h0000_0077);
      @(posedge clk); #1;
      drive(1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      @(posedge clk); #3;
      rst1_n = 1'b0;
      #2;
      chk_reset_state(1);
      @(posedge clk); #1;
      rst1_n = 1'b1;
      leds_m[1] = '0; err_m[1] = '0; have_prev[1] = 1'b0;
      idle(1, 8);
      chk("leds3_after_abort", {24'h0, leds1}, 32'h0);
      chk("rdata3_after_abort", bus1.cpu_rdata, 32'h0);
      req(1, 1'b0, 32'hE000_0008, 4'h0, 32'h0);
      drain(1);
      req(1, 1'b0, 32'h40, 4'h0, 32'h0);
      drain(1);
      idle(0, 4);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/cpu_dmem_responder.md
Name: cpu_dmem_responder

Overview:
- Responder (target) end of the CPU data bus.
- Accepts single-beat read/write requests and serves them from on-chip RAM with byte-lane write strobes, or from a small MMIO register window.
- Returns cpu_rdata and a one-cycle cpu_ack after a programmable number of wait states.
- Sits between the cpu data-bus outputs and memory, so the CPU can be simulated and synthesised standalone.

Parameters:
- ADDR_BITS, 12, byte-address width of RAM; RAM holds 2^(ADDR_BITS-2) 32-bit words.
- WAIT_STATES, 0, extra cycles inserted before ack; legal range 0..15.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- cpu_request  in  1  one-cycle pulse; address, write, wstrb and wdata are valid in this cycle.
- cpu_address  in  32  byte address; bits [1:0] ignored (word access).
- cpu_write  in  1  1 = write, 0 = read.
- cpu_wstrb  in  4  byte-lane enables for writes; bit n selects wdata[8n+7:8n].
- cpu_wdata  in  32  write data.
- cpu_rdata  out  32  read data, valid only in the cpu_ack cycle.
- cpu_ack  out  1  one-cycle completion pulse for both reads and writes.
- leds  out  8  LED register bits [7:0].
- proto_error  out  1  sticky flag: a request arrived while busy.

Behaviour:
- Reset (reset=0, async):
  - State goes to IDLE.
  - cpu_ack=0, cpu_rdata=0, leds=0, proto_error=0.
  - Cycle counter and err_count are cleared.
  - RAM contents are not reset.
- FSM states IDLE, WAIT, RESP:
  - IDLE + cpu_request: capture address, write, wstrb and wdata; load wait counter with WAIT_STATES. Go to WAIT if WAIT_STATES>0, else RESP.
  - WAIT: decrement the counter each cycle; go to RESP on the cycle the counter reaches 0.
  - RESP: drive cpu_ack=1 for exactly one cycle. Go to IDLE, or re-capture if cpu_request=1 in this same cycle (back-to-back requests are accepted).
  - Latency: cpu_ack is high exactly WAIT_STATES+1 cycles after the cpu_request cycle. With WAIT_STATES=0, ack arrives in the next cycle.
- cpu_request during WAIT: the request is dropped (no ack is ever produced for it) and proto_error is set. proto_error is cleared only by reset.
- cpu_rdata is registered and updated only on entry to RESP. It holds its last value otherwise.
- Address decode uses the captured address:
  - RAM: address[31:ADDR_BITS]==0. Word index is address[ADDR_BITS-1:2].
  - MMIO: address[31:4]==28'hE000000.
    - 0x0 LEDS: RW; bits [7:0] used, upper bits read 0.
    - 0x4 CYCLES: RO 32-bit free-running counter; increments every cycle and wraps at 2^32.
    - 0x8 ERRCNT: RO 16-bit count of unmapped accesses, zero-extended; saturates at 0xFFFF.
    - 0xC: reads 0, writes ignored.
  - Anything else is unmapped: acked normally, read returns 0, write is dropped, ERRCNT += 1 (saturating).
- Writes:
  - Committed on the RESP-entry clock edge, so a following read observes them.
  - Only lanes with wstrb=1 are modified; wstrb=0000 is acked with no effect.
  - A write to LEDS applies wstrb[0] only.
  - Writes to CYCLES and ERRCNT are ignored, with no error counted.
- Reads return the full 32-bit word; the CPU performs byte/halfword extraction.
- A CYCLES read returns the counter value at the RESP-entry edge.
- Reset asserted mid-transaction abandons it: no ack, and any pending write is not committed.

Test Plan:
- Reset, then WAIT_STATES=0: write 0x0000_0010 data 0xCAFEBABE wstrb 1111, then read 0x10 -> each ack exactly 1 cycle after its request; read returns 0xCAFEBABE.
- Byte strobes: write 0x11223344 to 0x20, then write 0xAABBCCDD wstrb 0101, then read 0x20 -> 0x11BB33DD.
- WAIT_STATES=3: read request at cycle t -> cpu_ack high only at t+4. A second request at t+2 is dropped, proto_error=1, and exactly one ack is produced.
- Back-to-back: new request issued in the ack cycle -> accepted; second ack arrives 1 cycle later (WAIT_STATES=0); no proto_error.
- MMIO:
  - write 0x1A5 to 0xE0000000 -> leds=0xA5; read back 0x000000A5.
  - two CYCLES reads N cycles apart differ by N.
  - write to 0xE0000004 -> no change, ERRCNT unchanged.
- Unmapped 0x8000_0000: read -> rdata=0, ack given, ERRCNT=1. Then a write -> ERRCNT=2, RAM unchanged. Assert reset mid-WAIT -> no ack, cpu_rdata=0, leds=0, ERRCNT=0.
